sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Synchronous two-requester controller for the 8-bit asynchronous SRAM macro (strobes: cs, wr, rd; din/dout/addr buses).
- Arbitrates port A and port B with round-robin fairness.
- Sequences each granted access through setup, strobe and completion phases.
- Returns read data and a one-cycle acknowledge to the winning requester.
- Sits between the SRAM and the datapath blocks that share it; owns every SRAM strobe.

Parameters:
- ADDR_W, 8, SRAM address width.
- DATA_W, 8, SRAM data width.
- RD_WAIT, 2, cycles sram_rd_n is held low before read data is captured (legal range 1..15).

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst_n  input  1  synchronous, active-low reset.
- req_a  input  1  port A request; held high with addr_a/we_a/wdata_a stable until ack_a is sampled.
- we_a  input  1  port A operation: 1 = write, 0 = read.
- addr_a  input  ADDR_W  port A address.
- wdata_a  input  DATA_W  port A write data.
- ack_a  output  1  one-cycle completion pulse to port A.
- req_b, we_b, addr_b, wdata_b, ack_b: same as port A, for port B.
- rdata  output  DATA_W  read data; valid in the ack cycle and held until the next read capture.
- busy  output  1  high whenever the FSM is not in IDLE.
- sram_cs  output  1  SRAM chip select, active high.
- sram_wr  output  1  SRAM write strobe, active-high pulse.
- sram_rd_n  output  1  SRAM read enable, active low.
- sram_addr  output  ADDR_W  SRAM address.
- sram_din  output  DATA_W  SRAM write data.
- sram_dout  input  DATA_W  SRAM read data.

Behaviour:
- Reset (rst_n low at a rising edge), all synchronous:
  - FSM goes to IDLE.
  - sram_cs=0, sram_wr=0, sram_rd_n=1, sram_addr=0, sram_din=0.
  - ack_a=ack_b=0, rdata=0, busy=0, last_grant=B (port A wins the first tie).
- All outputs are registered.
- FSM states: IDLE, SETUP, WRITE, READ, DONE.
- IDLE:
  - If only one request is high, grant that port.
  - If both are high, grant the port other than last_grant.
  - On a grant: latch that port's addr/we/wdata into the transaction registers, update last_grant, go to SETUP.
  - With no request, stay in IDLE.
- SETUP (1 cycle):
  - sram_cs=1, sram_addr/sram_din from the latched values, sram_wr=0, sram_rd_n=1.
  - Next state is WRITE if the latched we=1, else READ.
- WRITE (1 cycle): sram_wr=1, cs held, addr/din held; next state DONE.
- READ (RD_WAIT cycles):
  - sram_rd_n=0, cs held, addr held; a 4-bit counter counts the cycles.
  - In the last cycle, capture sram_dout into rdata.
  - Next state DONE.
- DONE (1 cycle):
  - sram_wr=0, sram_rd_n=1, sram_cs=0.
  - Ack of the granted port = 1 (never both acks).
  - Next state IDLE.
- Latency, with req sampled in IDLE at edge N:
  - Write: ack high in cycle N+3.
  - Read: ack high in cycle N+2+RD_WAIT (N+4 at default).
- Handshake:
  - A requester deasserts req (or presents a new transaction) at the edge where it samples ack=1.
  - A req still high in the IDLE cycle after DONE is treated as a new request.
  - Request inputs are ignored outside IDLE.
  - Changes to addr/wdata/we after the grant have no effect.
- Strobe ordering: sram_wr and sram_rd_n are never active simultaneously, and are never active while sram_cs=0. Address and data are stable one cycle before and during any strobe.
- Fairness: when both ports hold requests continuously, grants alternate A, B, A, B…; minimum turnaround is one IDLE cycle between transactions.
- Write data is never reflected on rdata; rdata changes only on read capture or reset.
- Reset mid-operation:
  - The transaction is aborted with no ack and all strobes go inactive on that edge.
  - An aborted write may or may not have reached the SRAM (undefined); an aborted read leaves rdata=0.

Decomposition:
- Shared package/header sram_ctrl_pkg holds:
  - FSM state encoding (IDLE=0, SETUP=1, WRITE=2, READ=3, DONE=4, 3-bit).
  - Port IDs (PORT_A=0, PORT_B=1).
  - Default ADDR_W, DATA_W and RD_WAIT constants.
- Sub-module rr_arb2: combinational two-way round-robin grant from req_a, req_b and last_grant. The FSM and datapath registers stay in the top module.

Test Plan:
- Write then read, port A: req_a, we_a=1, addr 0x9A, wdata 0xB5. Expect sram_wr high for exactly one cycle at N+2 with sram_addr=0x9A and sram_din=0xB5, and ack_a at N+3. Then read 0x9A: sram_rd_n low for 2 cycles, ack_a at N+4, rdata=0xB5.
- Overwrite, port B: write 0xB0 to 0x9A, then read it from port A. Expect rdata=0xB0, ack_b only on the write, ack_a only on the read.
- Simultaneous requests out of reset: A writes 0x11 to 0x01, B writes 0x22 to 0x02. Expect A granted first, B granted in the IDLE after A's DONE; reading 0x01/0x02 returns 0x11/0x22.
- Continuous contention: both ports hold requests for 6 transactions. Expect ack order A,B,A,B,A,B, busy low exactly one cycle between transactions, and no strobe overlap (assertion).
- Reset mid-read: rst_n low in the first READ cycle. Expect on that edge sram_rd_n=1, sram_cs=0, no ack, rdata=0, busy=0, and the next tie granted to A.
- RD_WAIT=4 instance: read of a previously written 0x5A. Expect sram_rd_n low exactly 4 cycles, ack at N+6, rdata=0x5A.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the two-port SRAM controller: FSM encoding,
// port identifiers and the default bus widths / read wait.
package sram_ctrl_pkg;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_RD_WAIT = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    WRITE = 3'd2,
    READ  = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin arbiter: a lone request wins outright,
// a tie goes to the port that did not win last time.
module rr_arb2
  import sram_ctrl_pkg::*;
(
  input  logic  req_a,
  input  logic  req_b,
  input  port_t last_grant,
  output logic  grant_valid,
  output port_t grant
);

  always_comb begin
    grant_valid = req_a | req_b;
    if (req_a && req_b) begin
      grant = (last_grant == PORT_A) ? PORT_B : PORT_A;
    end else if (req_a) begin
      grant = PORT_A;
    end else begin
      grant = PORT_B;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-requester controller for the asynchronous 8-bit SRAM: round-robin grant,
// setup/strobe/done sequencing, read capture and a one-cycle ack per access.
module sram_port_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RD_WAIT = DEF_RD_WAIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              ack_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              ack_b,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              sram_cs,
  output logic              sram_wr,
  output logic              sram_rd_n,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout
);

  state_t            state_q, state_d;
  port_t             last_grant, txn_port, grant;
  logic              grant_valid, txn_we, rd_last, take_grant;
  logic [3:0]        rd_cnt;
  logic              cs_d, wr_d, rd_n_d, ack_a_d, ack_b_d, busy_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] din_d, rdata_d;

  rr_arb2 u_arb (
    .req_a       (req_a),
    .req_b       (req_b),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  assign take_grant = (state_q == IDLE) && grant_valid;
  assign rd_last    = (rd_cnt == 4'(RD_WAIT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_grant <= PORT_B;
      txn_port   <= PORT_A;
      txn_we     <= 1'b0;
      rd_cnt     <= 4'd0;
    end else begin
      state_q <= state_d;
      if (take_grant) begin
        last_grant <= grant;
        txn_port   <= grant;
        txn_we     <= (grant == PORT_A) ? we_a : we_b;
      end
      rd_cnt <= (state_q == READ && !rd_last) ? rd_cnt + 4'd1 : 4'd0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_valid) state_d = SETUP;
      SETUP:   state_d = txn_we ? WRITE : READ;
      WRITE:   state_d = DONE;
      READ:    if (rd_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every pin comes straight off a flop.
  always_comb begin
    cs_d    = (state_d == SETUP) || (state_d == WRITE) || (state_d == READ);
    wr_d    = (state_d == WRITE);
    rd_n_d  = (state_d != READ);
    busy_d  = (state_d != IDLE);
    ack_a_d = (state_d == DONE) && (txn_port == PORT_A);
    ack_b_d = (state_d == DONE) && (txn_port == PORT_B);
    addr_d  = sram_addr;
    din_d   = sram_din;
    rdata_d = rdata;
    if (take_grant) begin
      addr_d = (grant == PORT_A) ? addr_a : addr_b;
      din_d  = (grant == PORT_A) ? wdata_a : wdata_b;
    end
    if (state_q == READ && rd_last) begin
      rdata_d = sram_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sram_cs   <= 1'b0;
      sram_wr   <= 1'b0;
      sram_rd_n <= 1'b1;
      sram_addr <= '0;
      sram_din  <= '0;
      ack_a     <= 1'b0;
      ack_b     <= 1'b0;
      busy      <= 1'b0;
      rdata     <= '0;
    end else begin
      sram_cs   <= cs_d;
      sram_wr   <= wr_d;
      sram_rd_n <= rd_n_d;
      sram_addr <= addr_d;
      sram_din  <= din_d;
      ack_a     <= ack_a_d;
      ack_b     <= ack_b_d;
      busy      <= busy_d;
      rdata     <= rdata_d;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: transaction-level reference model
// with directed scenarios, contention, mid-read reset and random traffic.
module tb_sram_port_arbiter;

  localparam int RD_WAIT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       req_a, we_a, req_b, we_b;
  logic [7:0] addr_a, wdata_a, addr_b, wdata_b;
  logic       ack_a, ack_b, busy, sram_cs, sram_wr, sram_rd_n;
  logic [7:0] rdata, sram_addr, sram_din, sram_dout;

  logic       req4_a, we4_a, req4_b, we4_b;
  logic [7:0] addr4_a, wdata4_a, addr4_b, wdata4_b;
  logic       ack4_a, ack4_b, busy4, sram4_cs, sram4_wr, sram4_rd_n;
  logic [7:0] rdata4, sram4_addr, sram4_din, sram4_dout;

  logic [7:0] mem  [256] = '{default: 8'h00};
  logic [7:0] mem4 [256] = '{default: 8'h00};

  sram_port_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_WAIT(RD_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a), .ack_a(ack_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b), .ack_b(ack_b),
    .rdata(rdata), .busy(busy),
    .sram_cs(sram_cs), .sram_wr(sram_wr), .sram_rd_n(sram_rd_n),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  sram_port_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_WAIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .req_a(req4_a), .we_a(we4_a), .addr_a(addr4_a), .wdata_a(wdata4_a), .ack_a(ack4_a),
    .req_b(req4_b), .we_b(we4_b), .addr_b(addr4_b), .wdata_b(wdata4_b), .ack_b(ack4_b),
    .rdata(rdata4), .busy(busy4),
    .sram_cs(sram4_cs), .sram_wr(sram4_wr), .sram_rd_n(sram4_rd_n),
    .sram_addr(sram4_addr), .sram_din(sram4_din), .sram_dout(sram4_dout)
  );

  // Behavioural asynchronous SRAMs: write on the strobe, combinational read.
  always @(posedge clk) begin
    if (sram_cs && sram_wr) mem[sram_addr] <= sram_din;
    if (sram4_cs && sram4_wr) mem4[sram4_addr] <= sram4_din;
  end
  assign sram_dout  = (sram_cs && !sram_rd_n) ? mem[sram_addr] : 8'h00;
  assign sram4_dout = (sram4_cs && !sram4_rd_n) ? mem4[sram4_addr] : 8'h00;

  int         checks = 0;
  int         errors = 0;
  int         e = 0;
  int         txns = 0;
  int         mode = 0;
  logic [7:0] ref_mem [256] = '{default: 8'h00};
  logic [7:0] exp_rdata;
  logic       m_busy, m_last, m_port, m_we;
  logic [7:0] m_addr, m_wdata;
  int         m_grant_edge, m_ack_edge, m_free_edge;
  logic       ack_log [$];

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at edge %0d", tag, act, exp, e);
    end
  endtask

  task automatic newTxn(input logic p);
    if (!p) begin
      req_a = 1'b1; we_a = 1'($urandom_range(0, 1));
      addr_a = 8'($urandom_range(0, 7)); wdata_a = 8'($urandom);
    end else begin
      req_b = 1'b1; we_b = 1'($urandom_range(0, 1));
      addr_b = 8'($urandom_range(0, 7)); wdata_b = 8'($urandom);
    end
  endtask

  task automatic applyStimulus(input logic p, input logic we, input logic [7:0] addr,
                               input logic [7:0] wdata);
    if (!p) begin
      req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wdata;
    end else begin
      req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wdata;
    end
  endtask

  // One clock: advance the transaction model, compare every output, then drive.
  task automatic tick();
    logic ack_now_a, ack_now_b, grant_now, rst_edge, in_txn, exp_cs, exp_wr, exp_rd_n;
    @(posedge clk);
    e++;
    ack_now_a = 1'b0; ack_now_b = 1'b0; grant_now = 1'b0;
    rst_edge = !rst_n;
    if (rst_edge) begin
      m_busy = 1'b0; m_last = 1'b1; exp_rdata = 8'h00; m_free_edge = e + 1;
    end else if (m_busy) begin
      if (e == m_ack_edge) begin
        if (m_port) ack_now_b = 1'b1; else ack_now_a = 1'b1;
        if (m_we) ref_mem[m_addr] = m_wdata; else exp_rdata = ref_mem[m_addr];
        m_busy = 1'b0; m_free_edge = e + 2; txns++;
        ack_log.push_back(m_port);
      end
    end else if (e >= m_free_edge && (req_a || req_b)) begin
      m_port  = (req_a && req_b) ? !m_last : !req_a;
      m_last  = m_port;
      m_we    = m_port ? we_b : we_a;
      m_addr  = m_port ? addr_b : addr_a;
      m_wdata = m_port ? wdata_b : wdata_a;
      m_grant_edge = e;
      m_ack_edge   = e + (m_we ? 2 : 1 + RD_WAIT);
      m_busy = 1'b1; grant_now = 1'b1;
    end
    #1;
    in_txn   = m_busy || ack_now_a || ack_now_b;
    exp_cs   = in_txn && (e < m_ack_edge);
    exp_wr   = in_txn && m_we && (e == m_grant_edge + 1);
    exp_rd_n = !(in_txn && !m_we && (e > m_grant_edge) && (e < m_ack_edge));
    checkOutput("ack_a", 32'(ack_a), 32'(ack_now_a));
    checkOutput("ack_b", 32'(ack_b), 32'(ack_now_b));
    checkOutput("busy", 32'(busy), 32'(in_txn));
    checkOutput("sram_cs", 32'(sram_cs), 32'(exp_cs));
    checkOutput("sram_wr", 32'(sram_wr), 32'(exp_wr));
    checkOutput("sram_rd_n", 32'(sram_rd_n), 32'(exp_rd_n));
    checkOutput("rdata", 32'(rdata), 32'(exp_rdata));
    checkOutput("strobe_overlap", 32'(sram_wr && !sram_rd_n), 32'd0);
    checkOutput("strobe_without_cs", 32'((sram_wr || !sram_rd_n) && !sram_cs), 32'd0);
    if (exp_cs) checkOutput("sram_addr", 32'(sram_addr), 32'(m_addr));
    if (exp_cs && m_we) checkOutput("sram_din", 32'(sram_din), 32'(m_wdata));
    if (rst_edge) begin
      checkOutput("rst_addr", 32'(sram_addr), 32'd0);
      checkOutput("rst_din", 32'(sram_din), 32'd0);
    end
    if (ack_now_a) begin
      if (mode == 2 || (mode == 1 && $urandom_range(0, 3) != 0)) newTxn(1'b0); else req_a = 1'b0;
    end
    if (ack_now_b) begin
      if (mode == 2 || (mode == 1 && $urandom_range(0, 3) != 0)) newTxn(1'b1); else req_b = 1'b0;
    end
    if (mode == 1) begin
      if (!req_a && $urandom_range(0, 2) == 0) newTxn(1'b0);
      if (!req_b && $urandom_range(0, 2) == 0) newTxn(1'b1);
    end
    // Scrambling the granted port's fields must not disturb the running access.
    if (grant_now && mode != 0 && $urandom_range(0, 1) == 1) newTxn(m_port);
  endtask

  task automatic drain();
    int n = 0;
    while ((req_a || req_b || m_busy) && n < 200) begin
      tick();
      n++;
    end
    if (req_a || req_b || m_busy) checkOutput("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int   n, rdlow, start;
    logic ack_seen;
    rst_n = 1'b0;
    req_a = 0; we_a = 0; addr_a = 0; wdata_a = 0;
    req_b = 0; we_b = 0; addr_b = 0; wdata_b = 0;
    req4_a = 0; we4_a = 0; addr4_a = 0; wdata4_a = 0;
    req4_b = 0; we4_b = 0; addr4_b = 0; wdata4_b = 0;
    m_busy = 0; m_last = 1; m_port = 0; m_we = 0; m_addr = 0; m_wdata = 0;
    m_grant_edge = 0; m_ack_edge = 0; m_free_edge = 0; exp_rdata = 0;
    tick();
    tick();
    checkOutput("reset_rd_n", 32'(sram_rd_n), 32'd1);
    checkOutput("reset_busy4", 32'(busy4), 32'd0);
    rst_n = 1'b1;

    $display("[TB] port A write then read 0x9A");
    applyStimulus(1'b0, 1'b1, 8'h9A, 8'hB5); drain();
    applyStimulus(1'b0, 1'b0, 8'h9A, 8'h00); drain();
    checkOutput("read_9a", 32'(rdata), 32'hB5);

    $display("[TB] port B overwrite, port A read");
    ack_log.delete();
    applyStimulus(1'b1, 1'b1, 8'h9A, 8'hB0); drain();
    applyStimulus(1'b0, 1'b0, 8'h9A, 8'h00); drain();
    checkOutput("overwrite_rdata", 32'(rdata), 32'hB0);
    checkOutput("overwrite_acks", 32'(ack_log.size()), 32'd2);
    checkOutput("overwrite_first_b", 32'(ack_log[0]), 32'd1);
    checkOutput("overwrite_second_a", 32'(ack_log[1]), 32'd0);

    $display("[TB] simultaneous writes out of reset");
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    ack_log.delete();
    applyStimulus(1'b0, 1'b1, 8'h01, 8'h11);
    applyStimulus(1'b1, 1'b1, 8'h02, 8'h22);
    drain();
    checkOutput("tie_first_a", 32'(ack_log[0]), 32'd0);
    checkOutput("tie_second_b", 32'(ack_log[1]), 32'd1);
    applyStimulus(1'b0, 1'b0, 8'h01, 8'h00); drain();
    checkOutput("read_01", 32'(rdata), 32'h11);
    applyStimulus(1'b1, 1'b0, 8'h02, 8'h00); drain();
    checkOutput("read_02", 32'(rdata), 32'h22);

    $display("[TB] continuous contention");
    ack_log.delete();
    start = txns; n = 0; mode = 2;
    newTxn(1'b0); newTxn(1'b1);
    while (txns < start + 6 && n < 200) begin tick(); n++; end
    mode = 0;
    drain();
    checkOutput("contend_count", 32'(ack_log.size() >= 6), 32'd1);
    for (int i = 0; i < 6; i++) checkOutput("contend_order", 32'(ack_log[i]), 32'(i % 2));

    $display("[TB] reset in first read cycle");
    applyStimulus(1'b0, 1'b0, 8'h9A, 8'h00);
    n = 0;
    while (!(m_busy && e == m_grant_edge + 1) && n < 20) begin tick(); n++; end
    if (n >= 20) checkOutput("reach_read_timeout", 32'd1, 32'd0);
    rst_n = 1'b0; req_a = 1'b0;
    tick();
    checkOutput("abort_rd_n", 32'(sram_rd_n), 32'd1);
    checkOutput("abort_cs", 32'(sram_cs), 32'd0);
    checkOutput("abort_ack", 32'(ack_a), 32'd0);
    checkOutput("abort_rdata", 32'(rdata), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    ack_log.delete();
    applyStimulus(1'b0, 1'b1, 8'h05, 8'h55);
    applyStimulus(1'b1, 1'b1, 8'h06, 8'h66);
    drain();
    checkOutput("post_reset_tie_a", 32'(ack_log[0]), 32'd0);

    $display("[TB] random traffic");
    mode = 1;
    repeat (400) tick();
    mode = 0;
    drain();

    $display("[TB] RD_WAIT=4 instance");
    req4_a = 1'b1; we4_a = 1'b1; addr4_a = 8'h33; wdata4_a = 8'h5A;
    n = 0; ack_seen = 1'b0;
    while (!ack_seen && n < 40) begin @(posedge clk); n++; #1; ack_seen = ack4_a; end
    req4_a = 1'b0;
    checkOutput("rw4_write_latency", 32'(n), 32'd3);
    @(posedge clk); #1;
    req4_a = 1'b1; we4_a = 1'b0;
    n = 0; rdlow = 0; ack_seen = 1'b0;
    while (!ack_seen && n < 40) begin
      @(posedge clk); n++; #1;
      if (!sram4_rd_n) rdlow++;
      ack_seen = ack4_a;
    end
    req4_a = 1'b0;
    checkOutput("rw4_read_latency", 32'(n), 32'd6);
    checkOutput("rw4_rd_low_cycles", 32'(rdlow), 32'd4);
    checkOutput("rw4_rdata", 32'(rdata4), 32'h5A);
    checkOutput("rw4_no_ack_b", 32'(ack4_b), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
